// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two core request ports, their read responses, and the RAM-side
// bus for mem_port_arbiter.
interface mem_port_arbiter_if #(
   parameter int addr_width = 12,
   parameter int data_width = 12,
   parameter int cnt_width  = 16
) ();
   logic                  req1;
   logic                  req2;
   logic                  we1;
   logic                  we2;
   logic [addr_width-1:0] addr1;
   logic [addr_width-1:0] addr2;
   logic [data_width-1:0] wdata1;
   logic [data_width-1:0] wdata2;
   logic                  gnt1;
   logic                  gnt2;
   logic                  rvalid1;
   logic                  rvalid2;
   logic [data_width-1:0] rdata1;
   logic [data_width-1:0] rdata2;
   logic [addr_width-1:0] mem_addr;
   logic [data_width-1:0] mem_wdata;
   logic                  mem_wren;
   logic [data_width-1:0] mem_q;
   logic [cnt_width-1:0]  stall1;
   logic [cnt_width-1:0]  stall2;
   logic                  busy;

   modport slave (
      input  req1, req2, we1, we2, addr1, addr2, wdata1, wdata2, mem_q,
      output gnt1, gnt2, rvalid1, rvalid2, rdata1, rdata2,
             mem_addr, mem_wdata, mem_wren, stall1, stall2, busy
   );

   modport master (
      output req1, req2, we1, we2, addr1, addr2, wdata1, wdata2, mem_q,
      input  gnt1, gnt2, rvalid1, rvalid2, rdata1, rdata2,
             mem_addr, mem_wdata, mem_wren, stall1, stall2, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two cores;
// at most one access per cycle, with read data returned one cycle after the grant.
module mem_port_arbiter #(
   parameter int addr_width = 12,
   parameter int data_width = 12,
   parameter int cnt_width  = 16
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [0:0] {
      PORT1 = 1'b0,
      PORT2 = 1'b1
   } port_e;

   localparam logic [cnt_width-1:0] CNT_MAX = {cnt_width{1'b1}};
   localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

   port_e                 last_gnt_q, last_gnt_d;
   logic                  rd_pend1_q, rd_pend1_d;
   logic                  rd_pend2_q, rd_pend2_d;
   logic [data_width-1:0] rdata1_q, rdata1_d;
   logic [data_width-1:0] rdata2_q, rdata2_d;
   logic [cnt_width-1:0]  stall1_q, stall1_d;
   logic [cnt_width-1:0]  stall2_q, stall2_d;
   logic                  gnt1_s;
   logic                  gnt2_s;
   logic                  rvalid1_s;
   logic                  rvalid2_s;

   // Port selection: a lone requester wins; on a tie the port not granted last wins.
   always_comb begin
      gnt1_s = 1'b0;
      gnt2_s = 1'b0;
      case ({bus.req1, bus.req2})
         2'b10: gnt1_s = 1'b1;
         2'b01: gnt2_s = 1'b1;
         2'b11: begin
            if (last_gnt_q == PORT2) begin
               gnt1_s = 1'b1;
            end else begin
               gnt2_s = 1'b1;
            end
         end
         default: begin
            gnt1_s = 1'b0;
            gnt2_s = 1'b0;
         end
      endcase
   end

   // RAM bus is driven only by the granted port; idle cycles present all zeros.
   always_comb begin
      bus.mem_addr  = {addr_width{1'b0}};
      bus.mem_wdata = {data_width{1'b0}};
      bus.mem_wren  = 1'b0;
      if (gnt1_s) begin
         bus.mem_addr  = bus.addr1;
         bus.mem_wdata = bus.wdata1;
         bus.mem_wren  = bus.we1;
      end else if (gnt2_s) begin
         bus.mem_addr  = bus.addr2;
         bus.mem_wdata = bus.wdata2;
         bus.mem_wren  = bus.we2;
      end else begin
         bus.mem_addr  = {addr_width{1'b0}};
         bus.mem_wdata = {data_width{1'b0}};
         bus.mem_wren  = 1'b0;
      end
   end

   // Next-state: read tracking, last grant, held read data and saturating stall counts.
   always_comb begin
      rd_pend1_d = gnt1_s & ~bus.we1;
      rd_pend2_d = gnt2_s & ~bus.we2;
      last_gnt_d = last_gnt_q;
      rdata1_d   = rdata1_q;
      rdata2_d   = rdata2_q;
      stall1_d   = stall1_q;
      stall2_d   = stall2_q;

      if (gnt1_s) begin
         last_gnt_d = PORT1;
      end else if (gnt2_s) begin
         last_gnt_d = PORT2;
      end else begin
         last_gnt_d = last_gnt_q;
      end

      if (rd_pend1_q) begin
         rdata1_d = bus.mem_q;
      end else begin
         rdata1_d = rdata1_q;
      end

      if (rd_pend2_q) begin
         rdata2_d = bus.mem_q;
      end else begin
         rdata2_d = rdata2_q;
      end

      if (bus.req1 && !gnt1_s && (stall1_q != CNT_MAX)) begin
         stall1_d = stall1_q + CNT_ONE;
      end else begin
         stall1_d = stall1_q;
      end

      if (bus.req2 && !gnt2_s && (stall2_q != CNT_MAX)) begin
         stall2_d = stall2_q + CNT_ONE;
      end else begin
         stall2_d = stall2_q;
      end
   end

   // State register; reset also drops any read still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt_q <= PORT2;
         rd_pend1_q <= 1'b0;
         rd_pend2_q <= 1'b0;
         rdata1_q   <= {data_width{1'b0}};
         rdata2_q   <= {data_width{1'b0}};
         stall1_q   <= {cnt_width{1'b0}};
         stall2_q   <= {cnt_width{1'b0}};
      end else begin
         last_gnt_q <= last_gnt_d;
         rd_pend1_q <= rd_pend1_d;
         rd_pend2_q <= rd_pend2_d;
         rdata1_q   <= rdata1_d;
         rdata2_q   <= rdata2_d;
         stall1_q   <= stall1_d;
         stall2_q   <= stall2_d;
      end
   end

   // A reset arriving while a read is in flight suppresses its response.
   assign rvalid1_s   = rd_pend1_q & ~reset;
   assign rvalid2_s   = rd_pend2_q & ~reset;

   assign bus.gnt1    = gnt1_s;
   assign bus.gnt2    = gnt2_s;
   assign bus.rvalid1 = rvalid1_s;
   assign bus.rvalid2 = rvalid2_s;
   assign bus.rdata1  = rvalid1_s ? bus.mem_q : rdata1_q;
   assign bus.rdata2  = rvalid2_s ? bus.mem_q : rdata2_q;
   assign bus.stall1  = stall1_q;
   assign bus.stall2  = stall2_q;
   assign bus.busy    = bus.req1 | bus.req2 | rd_pend1_q | rd_pend2_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: behavioural single-port RAM plus
// hand-computed expectations for reads, writes, contention, reset and saturation.
module tb_mem_port_arbiter;

   localparam int AW = 12;
   localparam int DW = 12;
   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic [DW-1:0] ram [0:(1<<AW)-1];
   int            vec_cnt;
   int            err_cnt;
   int            den;
   int            exp_stall;

   mem_port_arbiter_if #(.addr_width(AW), .data_width(DW), .cnt_width(CW)) bus ();

   mem_port_arbiter #(.addr_width(AW), .data_width(DW), .cnt_width(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM with a registered read port.
   always @(posedge clk) begin
      if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_q <= ram[bus.mem_addr];
   end

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt = vec_cnt + 1;
      if (act !== exp) begin
         err_cnt = err_cnt + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs after the falling edge; checks follow #1 later.
   task automatic drive(input logic rst,
                        input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic r2, input logic w2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
      @(negedge clk);
      reset      = rst;
      bus.req1   = r1;
      bus.we1    = w1;
      bus.addr1  = a1;
      bus.wdata1 = d1;
      bus.req2   = r2;
      bus.we2    = w2;
      bus.addr2  = a2;
      bus.wdata2 = d2;
      #1;
   endtask

   task automatic idle(input logic rst);
      drive(rst, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 12'h000, 12'h000);
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      for (int i = 0; i < (1 << AW); i++) ram[i] = 12'h000;
      ram[12'h010] = 12'hABC;
      ram[12'h001] = 12'h111;
      ram[12'h002] = 12'h222;
      bus.mem_q = 12'h000;
      reset = 1'b1;
      idle(1'b1);
      idle(1'b1);

      idle(1'b0);
      check_value("rst_rvalid1", 32'(bus.rvalid1), 32'h0);
      check_value("rst_rvalid2", 32'(bus.rvalid2), 32'h0);
      check_value("rst_rdata1", 32'(bus.rdata1), 32'h0);
      check_value("rst_stall1", 32'(bus.stall1), 32'h0);
      check_value("rst_stall2", 32'(bus.stall2), 32'h0);
      check_value("rst_gnt", 32'({bus.gnt1, bus.gnt2}), 32'h0);
      check_value("rst_wren", 32'(bus.mem_wren), 32'h0);
      check_value("rst_busy", 32'(bus.busy), 32'h0);

      // Single read by core 1
      drive(1'b0, 1'b1, 1'b0, 12'h010, 12'h000, 1'b0, 1'b0, 12'h000, 12'h000);
      check_value("rd_gnt", 32'({bus.gnt1, bus.gnt2}), 32'h2);
      check_value("rd_addr", 32'(bus.mem_addr), 32'h010);
      check_value("rd_wren", 32'(bus.mem_wren), 32'h0);
      check_value("rd_busy", 32'(bus.busy), 32'h1);
      idle(1'b0);
      check_value("rd_rvalid1", 32'(bus.rvalid1), 32'h1);
      check_value("rd_rdata1", 32'(bus.rdata1), 32'hABC);
      check_value("rd_rvalid2", 32'(bus.rvalid2), 32'h0);
      check_value("rd_busy_pend", 32'(bus.busy), 32'h1);
      idle(1'b0);
      check_value("rd_rvalid1_off", 32'(bus.rvalid1), 32'h0);
      check_value("rd_rdata1_hold", 32'(bus.rdata1), 32'hABC);
      check_value("rd_busy_off", 32'(bus.busy), 32'h0);

      // Core 2 write then read back
      drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 12'h020, 12'h555);
      check_value("wr_gnt2", 32'(bus.gnt2), 32'h1);
      check_value("wr_wren", 32'(bus.mem_wren), 32'h1);
      check_value("wr_addr", 32'(bus.mem_addr), 32'h020);
      check_value("wr_wdata", 32'(bus.mem_wdata), 32'h555);
      drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 12'h020, 12'h000);
      check_value("wr_rd_gnt2", 32'(bus.gnt2), 32'h1);
      check_value("wr_rd_wren", 32'(bus.mem_wren), 32'h0);
      check_value("wr_no_rvalid", 32'(bus.rvalid2), 32'h0);
      idle(1'b0);
      check_value("wr_rvalid2", 32'(bus.rvalid2), 32'h1);
      check_value("wr_rdata2", 32'(bus.rdata2), 32'h555);

      // Contention after a fresh reset: grants 1,2,1,2
      idle(1'b1);
      drive(1'b0, 1'b1, 1'b0, 12'h001, 12'h000, 1'b1, 1'b0, 12'h002, 12'h000);
      check_value("ct0_gnt", 32'({bus.gnt1, bus.gnt2}), 32'h2);
      check_value("ct0_addr", 32'(bus.mem_addr), 32'h001);
      drive(1'b0, 1'b1, 1'b0, 12'h001, 12'h000, 1'b1, 1'b0, 12'h002, 12'h000);
      check_value("ct1_gnt", 32'({bus.gnt1, bus.gnt2}), 32'h1);
      check_value("ct1_rvalid1", 32'(bus.rvalid1), 32'h1);
      check_value("ct1_rdata1", 32'(bus.rdata1), 32'h111);
      check_value("ct1_stall", 32'({bus.stall1, bus.stall2}), 32'h01);
      drive(1'b0, 1'b1, 1'b0, 12'h001, 12'h000, 1'b1, 1'b0, 12'h002, 12'h000);
      check_value("ct2_gnt", 32'({bus.gnt1, bus.gnt2}), 32'h2);
      check_value("ct2_rvalid", 32'({bus.rvalid1, bus.rvalid2}), 32'h1);
      check_value("ct2_rdata2", 32'(bus.rdata2), 32'h222);
      check_value("ct2_stall", 32'({bus.stall1, bus.stall2}), 32'h11);
      drive(1'b0, 1'b1, 1'b0, 12'h001, 12'h000, 1'b1, 1'b0, 12'h002, 12'h000);
      check_value("ct3_gnt", 32'({bus.gnt1, bus.gnt2}), 32'h1);
      check_value("ct3_rvalid", 32'({bus.rvalid1, bus.rvalid2}), 32'h2);
      check_value("ct3_stall", 32'({bus.stall1, bus.stall2}), 32'h12);
      idle(1'b0);
      check_value("ct4_rvalid", 32'({bus.rvalid1, bus.rvalid2}), 32'h1);
      check_value("ct4_rdata2", 32'(bus.rdata2), 32'h222);
      check_value("ct4_stall", 32'({bus.stall1, bus.stall2}), 32'h22);

      // Cross-core read-after-write
      drive(1'b0, 1'b1, 1'b1, 12'h030, 12'h0FF, 1'b0, 1'b0, 12'h000, 12'h000);
      check_value("raw_gnt1", 32'({bus.gnt1, bus.mem_wren}), 32'h3);
      drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 12'h030, 12'h000);
      check_value("raw_gnt2", 32'(bus.gnt2), 32'h1);
      idle(1'b0);
      check_value("raw_rvalid2", 32'(bus.rvalid2), 32'h1);
      check_value("raw_rdata2", 32'(bus.rdata2), 32'h0FF);

      // Reset while a core-1 read is in flight
      drive(1'b0, 1'b1, 1'b0, 12'h010, 12'h000, 1'b0, 1'b0, 12'h000, 12'h000);
      check_value("rmr_gnt1", 32'(bus.gnt1), 32'h1);
      idle(1'b1);
      check_value("rmr_rvalid1_n1", 32'(bus.rvalid1), 32'h0);
      idle(1'b0);
      check_value("rmr_rvalid1_n2", 32'(bus.rvalid1), 32'h0);
      check_value("rmr_rdata1", 32'(bus.rdata1), 32'h0);
      check_value("rmr_stall", 32'({bus.stall1, bus.stall2}), 32'h00);
      drive(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 12'h000, 12'h000);
      check_value("rmr_tie_port1", 32'({bus.gnt1, bus.gnt2}), 32'h2);

      // Saturation: core 2 denied every other cycle, counter stops at 0xF
      den = 1;
      for (int i = 0; i < 20; i++) begin
         exp_stall = (den > 15) ? 15 : den;
         drive(1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 12'h000, 12'h000);
         check_value($sformatf("sat_gnt2_%0d", i), 32'(bus.gnt2), 32'h1);
         check_value($sformatf("sat_stall2_%0d", i), 32'(bus.stall2), 32'(exp_stall));
         drive(1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 12'h000, 12'h000);
         check_value($sformatf("sat_tie_%0d", i), 32'({bus.gnt1, bus.gnt2}), 32'h2);
         den = den + 1;
      end
      idle(1'b0);
      check_value("sat_final2", 32'(bus.stall2), 32'hF);
      check_value("sat_final1", 32'(bus.stall1), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
